// File: rtl/condition_handler.sv
// Integer condition codes, branch evaluation and delay-slot control.
// Ports: Clk, Clr (async low); alu_flags/cc_we/is_bicc/cond/annul/stall in; icc/cin/taken/squash/dcti_err/state out.
module condition_handler (
  input  logic       Clk,
  input  logic       Clr,
  input  logic [3:0] alu_flags,
  input  logic       cc_we,
  input  logic       is_bicc,
  input  logic [3:0] cond,
  input  logic       annul,
  input  logic       stall,
  output logic [3:0] icc,
  output logic       cin,
  output logic       taken,
  output logic       squash,
  output logic       dcti_err,
  output logic       state
);

  typedef enum logic {
    IDLE = 1'b0,
    SLOT = 1'b1
  } state_t;

  state_t     st;
  logic [3:0] fl;
  logic       z, n, c, v;
  logic       base;
  logic       res;
  logic       acc;
  logic       cc_upd;

  // Flags being written this cycle are forwarded into the branch test.
  always_comb begin
    fl = cc_we ? alu_flags : icc;
    {z, n, c, v} = fl;
    base = 1'b0;
    case (cond[2:0])
      3'd0:    base = 1'b0;
      3'd1:    base = z;
      3'd2:    base = z | (n ^ v);
      3'd3:    base = n ^ v;
      3'd4:    base = c | z;
      3'd5:    base = c;
      3'd6:    base = n;
      3'd7:    base = v;
      default: base = 1'b0;
    endcase
    // cond[3] selects the complementary test.
    res = base ^ cond[3];
  end

  assign acc = (st == IDLE) & is_bicc & ~stall;

  // An annulled delay-slot instruction must not touch the codes.
  assign cc_upd = cc_we & ~stall & ~((st == SLOT) & squash);

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      st       <= IDLE;
      icc      <= 4'b0000;
      taken    <= 1'b0;
      squash   <= 1'b0;
      dcti_err <= 1'b0;
    end else begin
      if (cc_upd)
        icc <= alu_flags;
      dcti_err <= 1'b0;
      unique case (st)
        IDLE: begin
          if (acc) begin
            st     <= SLOT;
            taken  <= res;
            squash <= annul & (~res | (cond == 4'b1000));
          end
        end
        SLOT: begin
          if (!stall) begin
            st       <= IDLE;
            taken    <= 1'b0;
            squash   <= 1'b0;
            dcti_err <= is_bicc;
          end
        end
      endcase
    end
  end

  assign cin   = icc[1];
  assign state = st;

endmodule

// File: tb/tb_condition_handler.sv
// Bench for condition_handler: directed scenarios then random stimulus.
// Outputs compared against a rule-level reference model each cycle.
module tb_condition_handler;

  logic       Clk = 1'b0;
  logic       Clr;
  logic [3:0] alu_flags;
  logic       cc_we;
  logic       is_bicc;
  logic [3:0] cond;
  logic       annul;
  logic       stall;
  logic [3:0] icc;
  logic       cin;
  logic       taken;
  logic       squash;
  logic       dcti_err;
  logic       state;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] m_icc;
  logic       m_slot;
  logic       m_taken;
  logic       m_squash;
  logic       m_err;

  condition_handler dut (
    .Clk(Clk),
    .Clr(Clr),
    .alu_flags(alu_flags),
    .cc_we(cc_we),
    .is_bicc(is_bicc),
    .cond(cond),
    .annul(annul),
    .stall(stall),
    .icc(icc),
    .cin(cin),
    .taken(taken),
    .squash(squash),
    .dcti_err(dcti_err),
    .state(state)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, got, exp, $time);
  endtask

  task automatic check_all();
    chk("icc", {4'b0, icc}, {4'b0, m_icc});
    chk("cin", {7'b0, cin}, {7'b0, m_icc[1]});
    chk("taken", {7'b0, taken}, {7'b0, m_taken});
    chk("squash", {7'b0, squash}, {7'b0, m_squash});
    chk("dcti_err", {7'b0, dcti_err}, {7'b0, m_err});
    chk("state", {7'b0, state}, {7'b0, m_slot});
  endtask

  function automatic logic branch_true(input logic [3:0] cd,
                                       input logic [3:0] f);
    logic z, n, c, v;
    logic [7:0] p;
    {z, n, c, v} = f;
    p = {v, n, c, c | z, n ^ v, z | (n ^ v), z, 1'b0};
    return p[cd[2:0]] ^ cd[3];
  endfunction

  task automatic model_step();
    logic r;
    logic acc;
    logic [3:0] f;
    f = cc_we ? alu_flags : m_icc;
    r = branch_true(cond, f);
    acc = !m_slot && is_bicc && !stall;
    if (cc_we && !stall && !(m_slot && m_squash))
      m_icc = alu_flags;
    m_err = m_slot && !stall && is_bicc;
    if (acc) begin
      m_slot   = 1'b1;
      m_taken  = r;
      m_squash = annul && (!r || cond == 4'b1000);
    end else if (m_slot && !stall) begin
      m_slot   = 1'b0;
      m_taken  = 1'b0;
      m_squash = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_icc    = 4'b0;
    m_slot   = 1'b0;
    m_taken  = 1'b0;
    m_squash = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic cyc(input logic we, input logic [3:0] fl,
                     input logic b, input logic [3:0] cd,
                     input logic an, input logic st);
    @(negedge Clk);
    cc_we = we;
    alu_flags = fl;
    is_bicc = b;
    cond = cd;
    annul = an;
    stall = st;
    model_step();
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge Clk);
    cc_we = 0;
    is_bicc = 0;
    stall = 0;
    annul = 0;
    #2;
    Clr = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge Clk);
    Clr = 1'b1;
  endtask

  initial begin
    Clr = 1'b0;
    alu_flags = 4'b0;
    cc_we = 0;
    is_bicc = 0;
    cond = 4'b0;
    annul = 0;
    stall = 0;
    model_reset();
    #1;
    check_all();
    @(negedge Clk);
    Clr = 1'b1;

    // reset in the middle of SLOT with taken and squash set
    cyc(1, 4'b0110, 0, 4'b0000, 0, 0);
    cyc(0, 4'b0000, 1, 4'b1000, 1, 0);
    chk("pre_rst_taken", {7'b0, taken}, 8'd1);
    chk("pre_rst_squash", {7'b0, squash}, 8'd1);
    chk("pre_rst_cin", {7'b0, cin}, 8'd1);
    do_reset();
    chk("rst_cin", {7'b0, cin}, 8'd0);

    // load Z then branch on Z
    cyc(1, 4'b1000, 0, 4'b0000, 0, 0);
    cyc(0, 4'b0000, 1, 4'b0001, 0, 0);
    chk("z_taken", {7'b0, taken}, 8'd1);
    chk("z_squash", {7'b0, squash}, 8'd0);
    chk("z_state", {7'b0, state}, 8'd1);
    cyc(0, 4'b0000, 0, 4'b0000, 0, 0);
    chk("z_idle", {7'b0, state}, 8'd0);

    // forwarding with icc cleared
    do_reset();
    cyc(1, 4'b0100, 1, 4'b0011, 0, 0);
    chk("fwd_taken", {7'b0, taken}, 8'd1);
    chk("fwd_icc", {4'b0, icc}, 8'h04);

    // leave SLOT, then annulled always-branch blocks cc_we in slot
    cyc(0, 4'b0000, 0, 4'b0000, 0, 0);
    cyc(0, 4'b0000, 1, 4'b1000, 1, 0);
    chk("ba_taken", {7'b0, taken}, 8'd1);
    chk("ba_squash", {7'b0, squash}, 8'd1);
    cyc(1, 4'b0010, 0, 4'b0000, 0, 0);
    chk("ba_icc", {4'b0, icc}, 8'h04);

    // not-equal with Z set, annul on and off
    cyc(1, 4'b1000, 0, 4'b0000, 0, 0);
    cyc(0, 4'b0000, 1, 4'b1001, 1, 0);
    chk("bne_a_taken", {7'b0, taken}, 8'd0);
    chk("bne_a_squash", {7'b0, squash}, 8'd1);
    cyc(0, 4'b0000, 0, 4'b0000, 0, 0);
    cyc(0, 4'b0000, 1, 4'b1001, 0, 0);
    chk("bne_taken", {7'b0, taken}, 8'd0);
    chk("bne_squash", {7'b0, squash}, 8'd0);
    cyc(0, 4'b0000, 0, 4'b0000, 0, 0);

    // stall in SLOT, then branch in delay slot
    cyc(0, 4'b0000, 1, 4'b1000, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 4'b0000, 1, 4'b1000, 0, 1);
      chk("stl_taken", {7'b0, taken}, 8'd1);
      chk("stl_squash", {7'b0, squash}, 8'd1);
      chk("stl_state", {7'b0, state}, 8'd1);
    end
    cyc(0, 4'b0000, 1, 4'b1000, 0, 0);
    chk("dcti_pulse", {7'b0, dcti_err}, 8'd1);
    chk("dcti_state", {7'b0, state}, 8'd0);
    chk("dcti_taken", {7'b0, taken}, 8'd0);
    cyc(0, 4'b0000, 0, 4'b0000, 0, 0);
    chk("dcti_clear", {7'b0, dcti_err}, 8'd0);
    chk("dcti_noacc", {7'b0, state}, 8'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0)
        do_reset();
      else
        cyc($urandom_range(0, 9) < 4,
            4'($urandom_range(0, 15)),
            $urandom_range(0, 9) < 4,
            4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
